// File: rtl/i2s_rx_intf.sv
// I2S receiver: generates MCLK/SCLK/LRCLK from clk and deserializes 24-bit stereo words,
// presenting the top 16 bits of each channel with a single-cycle vld strobe.
module i2s_rx_intf (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SDout,
    output logic               MCLK,
    output logic               SCLK,
    output logic               LRCLK,
    output logic signed [15:0] lft_chnnl,
    output logic signed [15:0] rght_chnnl,
    output logic               vld
);

    typedef enum logic [1:0] {StSync, StLeft, StRight} state_e;

    state_e      state_q, state_d;
    logic [10:0] cnt_q;
    logic [15:0] shft_q;
    logic [15:0] shft_nxt;
    logic [15:0] lft_hold_q;
    logic [4:0]  slot;
    logic        smpl;
    logic        shift_en;
    logic        last_bit;
    logic        wrap;
    logic        cap_left;
    logic        cap_right;

    // Clocks come straight from counter flops so they are glitch-free.
    assign MCLK  = cnt_q[1];
    assign SCLK  = cnt_q[4];
    assign LRCLK = cnt_q[10];

    assign slot     = cnt_q[9:5];
    assign smpl     = (cnt_q[4:0] == 5'd15);
    assign shift_en = smpl && (slot != 5'd0) && (slot <= 5'd16);
    assign last_bit = smpl && (slot == 5'd16);
    assign wrap     = (cnt_q == 11'h7ff);
    // Capture paths take the bit arriving on this edge, not the stale register.
    assign shft_nxt = {shft_q[14:0], SDout};

    always_comb begin
        state_d   = state_q;
        cap_left  = 1'b0;
        cap_right = 1'b0;
        unique case (state_q)
            StSync: begin
                if (wrap) state_d = StLeft;
            end
            StLeft: begin
                cap_left = last_bit;
                if (cnt_q == 11'd1023) state_d = StRight;
            end
            StRight: begin
                cap_right = last_bit;
                if (wrap) state_d = StLeft;
            end
            default: state_d = StSync;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StSync;
            cnt_q      <= 11'd0;
            shft_q     <= 16'd0;
            lft_hold_q <= 16'd0;
            lft_chnnl  <= 16'sd0;
            rght_chnnl <= 16'sd0;
            vld        <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + 11'd1;
            vld     <= cap_right;
            if (shift_en) shft_q <= shft_nxt;
            if (cap_left) lft_hold_q <= shft_nxt;
            if (cap_right) begin
                lft_chnnl  <= lft_hold_q;
                rght_chnnl <= shft_nxt;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_intf.sv
// Directed bench for i2s_rx_intf: a codec model drives SDout from per-frame word tables,
// a monitor records vld pulses and clock behaviour, and the main block checks them.
module tb_i2s_rx_intf;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               SDout = 1'b0;
    logic               MCLK;
    logic               SCLK;
    logic               LRCLK;
    logic signed [15:0] lft_chnnl;
    logic signed [15:0] rght_chnnl;
    logic               vld;

    i2s_rx_intf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SDout     (SDout),
        .MCLK      (MCLK),
        .SCLK      (SCLK),
        .LRCLK     (LRCLK),
        .lft_chnnl (lft_chnnl),
        .rght_chnnl(rght_chnnl),
        .vld       (vld)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edges = 0;
    int clk_err = 0;
    int hold_err = 0;
    int dbl = 0;
    int vld_in_rst = 0;
    int vld_at[$];
    int vld_l[$];
    int vld_r[$];
    logic               prev_vld = 1'b0;
    logic signed [15:0] prev_l = 16'sd0;
    logic signed [15:0] prev_r = 16'sd0;

    logic [23:0] ltab[8];
    logic [23:0] rtab[8];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_edges(input int target);
        while (edges < target) @(negedge clk);
    endtask

    // Clock edges since reset release; equals the DUT frame counter (unwrapped).
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) edges = 0;
            else edges++;
        end
    end

    // Codec model: shifts on SCLK fall, one-bit delay after each LRCLK change, random padding.
    initial begin
        int          bit_idx;
        int          f;
        logic        last_lr;
        logic [23:0] cur_word;
        bit_idx  = 0;
        last_lr  = 1'b0;
        cur_word = 24'd0;
        forever begin
            @(negedge SCLK or negedge rst_n);
            #1;
            if (!rst_n) begin
                bit_idx = 0;
                last_lr = 1'b0;
            end else begin
                if (LRCLK !== last_lr) begin
                    last_lr  = LRCLK;
                    bit_idx  = 0;
                    f        = edges >> 11;
                    if (f > 7) f = 0;
                    cur_word = LRCLK ? rtab[f] : ltab[f];
                end else begin
                    bit_idx++;
                end
                if (bit_idx >= 1 && bit_idx <= 24) SDout = cur_word[24-bit_idx];
                else SDout = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_vld = 1'b0;
                prev_l   = 16'sd0;
                prev_r   = 16'sd0;
            end else begin
                if (MCLK !== edges[1] || SCLK !== edges[4] || LRCLK !== edges[10]) clk_err++;
                if (vld) begin
                    vld_at.push_back(edges);
                    vld_l.push_back(int'({16'h0, lft_chnnl}));
                    vld_r.push_back(int'({16'h0, rght_chnnl}));
                end
                if (vld && prev_vld) dbl++;
                if (!vld && (lft_chnnl !== prev_l || rght_chnnl !== prev_r)) hold_err++;
                prev_vld = vld;
                prev_l   = lft_chnnl;
                prev_r   = rght_chnnl;
            end
        end
    end

    initial begin
        int exp_at[5];
        int exp_l[5];
        int exp_r[5];
        int a;
        int l;
        int r;

        ltab = '{24'hffffff, 24'h000100, 24'h1234ab, 24'h1234cd, 24'h800000, 24'h5a5a00,
                 24'h0, 24'h0};
        rtab = '{24'hffffff, 24'h7fff00, 24'hfedc01, 24'hfedcef, 24'h7fffff, 24'ha5a5ff,
                 24'h0, 24'h0};
        exp_at = '{3600, 5648, 7696, 9744, 11792};
        exp_l  = '{'h0001, 'h1234, 'h1234, 'h8000, 'h5a5a};
        exp_r  = '{'h7fff, 'hfedc, 'hfedc, 'h7fff, 'ha5a5};

        repeat (3) @(negedge clk);
        check("rst_mclk", int'(MCLK), 0);
        check("rst_sclk", int'(SCLK), 0);
        check("rst_lrclk", int'(LRCLK), 0);
        check("rst_vld", int'(vld), 0);
        check("rst_lft", int'({16'h0, lft_chnnl}), 0);
        check("rst_rght", int'({16'h0, rght_chnnl}), 0);

        rst_n = 1'b1;
        wait_edges(1023);
        check("lrclk_lo_1023", int'(LRCLK), 0);
        wait_edges(1024);
        check("lrclk_hi_1024", int'(LRCLK), 1);
        wait_edges(2048);
        check("no_vld_frame0", vld_at.size(), 0);

        wait_edges(12000);
        check("vld_count", vld_at.size(), 5);
        for (int i = 0; i < 5; i++) begin
            a = (i < vld_at.size()) ? vld_at[i] : -1;
            l = (i < vld_l.size()) ? vld_l[i] : -1;
            r = (i < vld_r.size()) ? vld_r[i] : -1;
            check($sformatf("vld_edge%0d", i), a, exp_at[i]);
            check($sformatf("lft%0d", i), l, exp_l[i]);
            check($sformatf("rght%0d", i), r, exp_r[i]);
        end
        check("clk_shape", clk_err, 0);
        check("vld_single", dbl, 0);
        check("hold", hold_err, 0);

        // Mid-frame reset at cnt==700 of frame 3.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vld_at.delete();
        vld_l.delete();
        vld_r.delete();
        rst_n = 1'b1;
        wait_edges(6844);
        check("pre_rst_sclk", int'(SCLK), 1);
        check("pre_rst_lft", int'({16'h0, lft_chnnl}), 'h1234);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mclk", int'(MCLK), 0);
        check("mid_rst_sclk", int'(SCLK), 0);
        check("mid_rst_lrclk", int'(LRCLK), 0);
        check("mid_rst_vld", int'(vld), 0);
        check("mid_rst_lft", int'({16'h0, lft_chnnl}), 0);
        check("mid_rst_rght", int'({16'h0, rght_chnnl}), 0);
        ltab[0] = 24'h555555;
        rtab[0] = 24'haaaaaa;
        ltab[1] = 24'h0abcde;
        rtab[1] = 24'h0def12;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (vld) vld_in_rst++;
        end
        check("vld_in_reset", vld_in_rst, 0);
        vld_at.delete();
        vld_l.delete();
        vld_r.delete();
        rst_n = 1'b1;
        wait_edges(3599);
        check("no_vld_before_3600", vld_at.size(), 0);
        wait_edges(3700);
        check("post_rst_count", vld_at.size(), 1);
        a = (vld_at.size() > 0) ? vld_at[0] : -1;
        l = (vld_l.size() > 0) ? vld_l[0] : -1;
        r = (vld_r.size() > 0) ? vld_r[0] : -1;
        check("post_rst_edge", a, 3600);
        check("post_rst_lft", l, 'h0abc);
        check("post_rst_rght", r, 'h0def);
        check("clk_shape_final", clk_err, 0);
        check("vld_single_final", dbl, 0);
        check("hold_final", hold_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
